// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_pkg
//  Description : Shared definitions for the two-port Y86 ALU share block.
//                This package holds the ifun codes, the condition-code bit
//                positions, the CC reset value and the arbiter state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

    localparam int unsigned DATA_W = 64;

    // Y86 OPq ifun encodings
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_XOR = 4'd3;

    // Bit positions inside cc = {ZF, SF, OF}
    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    // Round-robin pointer: names the requester that wins a tie
    typedef enum logic [0:0] {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_e;

endpackage : alu_share_pkg
`default_nettype wire

// File: rtl/alu_share_ctrl_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational Y86 ALU, result = b OP a, with flag outputs.
//                Ports:
//                  fn     in   4      ifun (ADD/SUB/AND/XOR)
//                  a, b   in   WIDTH  operands (valA, valB)
//                  result out  WIDTH  b OP a, zero for an unknown fn
//                  zf/sf/of out 1     flags derived from result
//                  err    out  1      fn outside 0..3
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [3:0]       fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             err
);

    logic             w_sub;
    logic [WIDTH-1:0] w_a_inv;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_xor;

    // One adder serves ADD and SUB: b - a = b + ~a + 1. Carry-out is dropped.
    assign w_sub   = (fn == FN_SUB);
    assign w_a_inv = w_sub ? ~a : a;
    assign w_sum   = b + w_a_inv + {{(WIDTH-1){1'b0}}, w_sub};
    assign w_and   = b & a;
    assign w_xor   = b ^ a;

    always_comb begin
        result = '0;
        of     = 1'b0;
        err    = 1'b0;
        case (fn)
            FN_ADD: begin
                result = w_sum;
                of     = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            FN_SUB: begin
                result = w_sum;
                of     = (a[WIDTH-1] != b[WIDTH-1]) && (w_sum[WIDTH-1] != b[WIDTH-1]);
            end
            FN_AND:  result = w_and;
            FN_XOR:  result = w_xor;
            default: err    = 1'b1;
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[WIDTH-1];

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_ctrl
//  Description : Round-robin sharing of one Y86 ALU between two requesters.
//                It accepts at most one op per cycle and registers the result
//                one cycle later. It updates {ZF,SF,OF} on request.
//                Ports:
//                  clk, rst                      clock, sync active-high reset
//                  stall                         blocks all grants
//                  reqN_valid/ready              request handshake (N = 0,1)
//                  reqN_fn/a/b/setcc             op, operands, CC update enable
//                  respN_valid                   one-cycle result pulse
//                  resp_data                     shared registered result
//                  cc                            {ZF,SF,OF}
//                  fn_err                        accepted op had an invalid fn
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_fn,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_setcc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_fn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_setcc,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic [2:0]       cc,
    output logic             fn_err
);

    prio_e            r_prio;
    prio_e            w_prio_nxt;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc;

    logic [3:0]       w_fn;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_setcc;
    logic [WIDTH-1:0] w_result;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;
    logic             w_err;

    logic             r_resp0_valid;
    logic             r_resp1_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic [2:0]       r_cc;
    logic             r_fn_err;

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= PRIO0;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_prio_nxt = r_prio;

        // A requester wins when it is alone, or when both ask and it holds priority.
        if (!stall) begin
            w_gnt0 = req0_valid && (!req1_valid || (r_prio == PRIO0));
            w_gnt1 = req1_valid && (!req0_valid || (r_prio == PRIO1));
        end

        if (w_gnt0) begin
            w_prio_nxt = PRIO1;
        end else if (w_gnt1) begin
            w_prio_nxt = PRIO0;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_acc      = w_gnt0 || w_gnt1;

    // ------------------------------------------------------------------
    // Operand mux and ALU
    // ------------------------------------------------------------------
    assign w_fn    = w_gnt1 ? req1_fn    : req0_fn;
    assign w_a     = w_gnt1 ? req1_a     : req0_a;
    assign w_b     = w_gnt1 ? req1_b     : req0_b;
    assign w_setcc = w_gnt1 ? req1_setcc : req0_setcc;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .fn     (w_fn),
        .a      (w_a),
        .b      (w_b),
        .result (w_result),
        .zf     (w_zf),
        .sf     (w_sf),
        .of     (w_of),
        .err    (w_err)
    );

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp_data   <= '0;
            r_cc          <= CC_RESET;
            r_fn_err      <= 1'b0;
        end else begin
            r_resp0_valid <= w_gnt0;
            r_resp1_valid <= w_gnt1;
            r_fn_err      <= w_acc && w_err;
            if (w_acc) begin
                r_resp_data <= w_result;
            end
            if (w_acc && w_setcc && !w_err) begin
                r_cc[CC_ZF] <= w_zf;
                r_cc[CC_SF] <= w_sf;
                r_cc[CC_OF] <= w_of;
            end
        end
    end

    // Reset in the cycle a response is due cancels that response.
    assign resp0_valid = r_resp0_valid && !rst;
    assign resp1_valid = r_resp1_valid && !rst;
    assign fn_err      = r_fn_err && !rst;
    assign resp_data   = r_resp_data;
    assign cc          = r_cc;

endmodule : alu_share_ctrl
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_ctrl
//  Description : Directed self-checking bench for alu_share_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_fn, req1_fn;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_setcc, req1_setcc;
    logic             resp0_valid, resp1_valid;
    logic [WIDTH-1:0] resp_data;
    logic [2:0]       cc;
    logic             fn_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_fn     (req0_fn),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_setcc  (req0_setcc),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_fn     (req1_fn),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_setcc  (req1_setcc),
        .resp0_valid (resp0_valid),
        .resp1_valid (resp1_valid),
        .resp_data   (resp_data),
        .cc          (cc),
        .fn_err      (fn_err)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv0(input logic v, input logic [3:0] f, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s);
        req0_valid = v; req0_fn = f; req0_a = a; req0_b = b; req0_setcc = s;
    endtask

    task automatic drv1(input logic v, input logic [3:0] f, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s);
        req1_valid = v; req1_fn = f; req1_a = a; req1_b = b; req1_setcc = s;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        drv1(1'b0, 4'd0, '0, '0, 1'b0);

        // Reset values
        cyc(); cyc(); mid();
        chk("rst_cc",     64'(cc),          64'h4);
        chk("rst_data",   resp_data,        64'h0);
        chk("rst_resp0",  64'(resp0_valid), 64'h0);
        chk("rst_resp1",  64'(resp1_valid), 64'h0);
        chk("rst_fn_err", 64'(fn_err),      64'h0);

        // req0 ADD 15 + 32
        cyc(); rst = 1'b0;
        drv0(1'b1, 4'd0, 64'd15, 64'd32, 1'b1);
        mid();
        chk("add_ready0", 64'(req0_ready), 64'h1);
        chk("add_ready1", 64'(req1_ready), 64'h0);

        // req1 AND, no CC update
        cyc();
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        drv1(1'b1, 4'd2, 64'hAAAA_AAAA_AAAA_AAAB, 64'h5555_5555_5555_5555, 1'b0);
        mid();
        chk("add_resp0", 64'(resp0_valid), 64'h1);
        chk("add_resp1", 64'(resp1_valid), 64'h0);
        chk("add_data",  resp_data,        64'd47);
        chk("add_cc",    64'(cc),          64'h0);
        chk("and_ready1", 64'(req1_ready), 64'h1);

        cyc();
        drv1(1'b0, 4'd0, '0, '0, 1'b0);
        mid();
        chk("and_resp1", 64'(resp1_valid), 64'h1);
        chk("and_resp0", 64'(resp0_valid), 64'h0);
        chk("and_data",  resp_data,        64'h1);
        chk("and_cc",    64'(cc),          64'h0);

        cyc(); mid();
        chk("idle_resp1", 64'(resp1_valid), 64'h0);
        chk("hold_data",  resp_data,        64'h1);

        // Fresh reset, then both requesters valid for 4 cycles
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        drv0(1'b1, 4'd3, 64'd15, 64'd31, 1'b0);
        drv1(1'b1, 4'd2, 64'd31, 64'd63, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            mid();
            chk($sformatf("rr_ready0_%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
            chk($sformatf("rr_ready1_%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
            if (i > 0) begin
                chk($sformatf("rr_resp0_%0d", i), 64'(resp0_valid), 64'((i % 2) == 1));
                chk($sformatf("rr_resp1_%0d", i), 64'(resp1_valid), 64'((i % 2) == 0));
                chk($sformatf("rr_data_%0d", i), resp_data, ((i % 2) == 1) ? 64'd16 : 64'd31);
            end
        end
        cyc();
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        drv1(1'b0, 4'd0, '0, '0, 1'b0);
        mid();
        chk("rr_resp1_last", 64'(resp1_valid), 64'h1);
        chk("rr_data_last",  resp_data,        64'd31);
        chk("rr_cc",         64'(cc),          64'h4);

        // SUB with signed overflow: 0x8000..0 - 1
        cyc();
        drv0(1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
        mid();
        chk("sub_ready0", 64'(req0_ready), 64'h1);
        cyc();
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        mid();
        chk("sub_data", resp_data, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_cc",   64'(cc),   64'h1);

        // XOR to zero sets ZF
        cyc();
        drv1(1'b1, 4'd3, 64'd5, 64'd5, 1'b1);
        cyc();
        drv1(1'b0, 4'd0, '0, '0, 1'b0);
        mid();
        chk("zf_resp1", 64'(resp1_valid), 64'h1);
        chk("zf_data",  resp_data,        64'h0);
        chk("zf_cc",    64'(cc),          64'h4);

        // ADD with signed overflow: 0x7FFF..F + 1
        cyc();
        drv0(1'b1, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        cyc();
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        mid();
        chk("addof_data", resp_data, 64'h8000_0000_0000_0000);
        chk("addof_cc",   64'(cc),   64'h3);

        // Stall with both valid; pointer currently favours requester 1
        cyc();
        stall = 1'b1;
        drv0(1'b1, 4'd0, 64'd1, 64'd1, 1'b0);
        drv1(1'b1, 4'd0, 64'd2, 64'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            mid();
            chk($sformatf("stall_ready0_%0d", i), 64'(req0_ready), 64'h0);
            chk($sformatf("stall_ready1_%0d", i), 64'(req1_ready), 64'h0);
            if (i > 0) begin
                chk($sformatf("stall_resp0_%0d", i), 64'(resp0_valid), 64'h0);
                chk($sformatf("stall_resp1_%0d", i), 64'(resp1_valid), 64'h0);
            end
        end
        chk("stall_cc", 64'(cc), 64'h3);
        cyc();
        stall = 1'b0;
        mid();
        chk("unstall_ready1", 64'(req1_ready), 64'h1);
        chk("unstall_ready0", 64'(req0_ready), 64'h0);
        cyc();
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        drv1(1'b0, 4'd0, '0, '0, 1'b0);
        mid();
        chk("unstall_resp1", 64'(resp1_valid), 64'h1);
        chk("unstall_data",  resp_data,        64'd4);
        chk("unstall_cc",    64'(cc),          64'h3);

        // Invalid fn
        cyc();
        drv0(1'b1, 4'd7, 64'd3, 64'd4, 1'b1);
        mid();
        chk("fn7_ready0", 64'(req0_ready), 64'h1);
        cyc();
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        mid();
        chk("fn7_resp0",  64'(resp0_valid), 64'h1);
        chk("fn7_data",   resp_data,        64'h0);
        chk("fn7_err",    64'(fn_err),      64'h1);
        chk("fn7_cc",     64'(cc),          64'h3);
        cyc(); mid();
        chk("fn7_err_off", 64'(fn_err), 64'h0);

        // Reset in the cycle after an acceptance
        cyc();
        drv0(1'b1, 4'd0, 64'd1, 64'd2, 1'b1);
        mid();
        chk("rstf_ready0", 64'(req0_ready), 64'h1);
        cyc();
        drv0(1'b0, 4'd0, '0, '0, 1'b0);
        rst = 1'b1;
        mid();
        chk("rstf_resp0", 64'(resp0_valid), 64'h0);
        cyc();
        rst = 1'b0;
        mid();
        chk("rstf_resp0_after", 64'(resp0_valid), 64'h0);
        chk("rstf_cc",          64'(cc),          64'h4);
        chk("rstf_data",        resp_data,        64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_share_ctrl
`default_nettype wire

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Shares one 64-bit Y86 ALU (ADD/SUB/AND/XOR) between two requesters: port 0 is the execute stage's OPq path and port 1 is the address/auxiliary path. It arbitrates round-robin, issues at most one operation per cycle, and returns a registered result one cycle later. When the winning requester asks for it, the block also updates the Y86 condition codes (ZF, SF, OF). It sits in the execute stage in front of the existing combinational ALU units.

## Interface
- WIDTH, 64, operand/result width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; while high, no grant is issued
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_fn / req1_fn  in  4  Y86 ifun: 0 ADD, 1 SUB, 2 AND, 3 XOR
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands (valA, valB)
- req0_setcc / req1_setcc  in  1  update CC on completion
- resp0_valid / resp1_valid  out  1  one-cycle result pulse
- resp_data  out  WIDTH  registered result, shared by both response ports
- cc  out  3  {ZF, SF, OF}, registered
- fn_err  out  1  one-cycle pulse: accepted op had an invalid fn

## Operation
- Arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester named by prio_q.
  - After any grant, prio_q points to the other requester.
  - reqN_ready = grant to N and !stall.
  - At most one ready is high per cycle.
- Handshake: a transfer occurs when valid and ready are both high. There is no response backpressure; the consumer must sample resp on the pulse.
- Arithmetic (Y86 order, result = b OP a):
  - ADD: b+a
  - SUB: b−a
  - AND: b&a
  - XOR: b^a
  - Carries out of WIDTH are discarded.
- Condition codes, on accepted ops with setcc=1 and a valid fn:
  - ZF = (result == 0)
  - SF = result[WIDTH-1]
  - ADD: OF = (a[msb]==b[msb]) & (r[msb]!=a[msb])
  - SUB: OF = (a[msb]!=b[msb]) & (r[msb]!=b[msb])
  - AND/XOR: OF = 0
- Invalid fn (4–15): the op is still accepted, resp_data=0, respN_valid pulses, fn_err pulses, cc is unchanged.
- State machine (arbiter pointer):
  - PRIO0 and PRIO1 are the states.
  - PRIO0 → PRIO1 on any grant to 0; PRIO1 → PRIO0 on any grant to 1.
  - With no grant, the state holds.

## Timing
- Latency: exactly 1 cycle. An op accepted in cycle t gives respN_valid, resp_data, cc and fn_err in cycle t+1.
- Throughput: 1 op per cycle, with back-to-back grants allowed.
- Stall:
  - Both readies are forced low.
  - prio_q holds.
  - A response already in flight still appears the next cycle.
  - cc holds unless that in-flight op updates it.
- Reset:
  - Values: prio_q=PRIO0, resp0_valid=resp1_valid=0, resp_data=0, cc=3'b100 (ZF set), fn_err=0.
  - An op accepted in the cycle rst is high is discarded: no response and no CC update.
  - If rst is high in the cycle after an acceptance, the in-flight response is suppressed.
- Valid withdrawn without ready: allowed, with no side effects.
- resp_data holds its last value between pulses.

## Structure
- Package alu_share_pkg:
  - fn codes: FN_ADD=0, FN_SUB=1, FN_AND=2, FN_XOR=3
  - CC bit indices: CC_ZF=2, CC_SF=1, CC_OF=0
  - CC_RESET=3'b100
- Sub-module alu_core: combinational, fn/a/b → result, zf, sf, of, err. It reuses the existing 64-bit AND/XOR/adder units.
- Top level: arbiter FSM, operand mux, and output registers.

## Test plan
- Reset: hold rst 2 cycles → cc=100, resp_data=0, both resp_valid=0, fn_err=0.
- req0 ADD a=15, b=32, setcc=1 → req0_ready=1 same cycle; next cycle resp0_valid=1, resp_data=47, cc=000.
- req1 AND a=0xAAAAAAAAAAAAAAAB, b=0x5555555555555555, setcc=0 → resp1_valid=1, resp_data=0x1; cc unchanged.
- Both valid for 4 cycles after reset (req0 XOR 15^31, req1 AND 31&63) → grants alternate 0,1,0,1 → resp_data 16, 31, 16, 31.
- req0 SUB a=1, b=0x8000000000000000, setcc=1 → resp_data=0x7FFFFFFFFFFFFFFF, cc=001 (OF).
- Control cases:
  - stall=1 with both valid → no ready for the whole stall.
  - fn=7 → resp_data=0, fn_err pulse, cc unchanged.
  - rst asserted the cycle after an acceptance → no resp pulse.
